regfile_ctrl: RTL and testbench

REGFILE_CTRL -- requirements
Module: regfile_ctrl

---
 rtl/regfile_ctrl.sv | 113 +++++++++++
 tb/tb_regfile_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctrl.sv
// Button-driven register-file controller: one debounced press per step enters
// write (address, low byte, high byte) or read (A, B) operands from the switches.
module regfile_ctrl #(
  parameter int DBNC = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  input  logic [7:0]  sw,
  output logic [1:0]  mode,
  output logic [4:0]  wa,
  output logic [15:0] wd,
  output logic        we,
  output logic [4:0]  raA,
  output logic [4:0]  raB
);

  localparam logic [17:0] DBNC_M1 = 18'(DBNC - 1);

  typedef enum logic [2:0] {
    CMD, WD_LO, WD_HI, WRITE, SHOW_W, RD_B, SHOW_R
  } state_t;

  state_t      state;
  logic        sync1, sync2;
  logic        lvl;
  logic [17:0] cnt;
  logic        press;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl <= 1'b0;
      cnt <= '0;
    end else if (sync2 != lvl) begin
      if (cnt == DBNC_M1) begin
        lvl <= ~lvl;
        cnt <= '0;
      end else begin
        cnt <= cnt + 18'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Decoded from the flip condition so the FSM acts on the same edge the level rises.
  assign press = ~lvl & sync2 & (cnt == DBNC_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CMD;
      mode  <= 2'b00;
      wa    <= '0;
      wd    <= '0;
      we    <= 1'b0;
      raA   <= '0;
      raB   <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        CMD: if (press) begin
          if (sw[7]) begin
            wa    <= sw[4:0];
            state <= WD_LO;
            mode  <= 2'b01;
          end else begin
            raA   <= sw[4:0];
            state <= RD_B;
            mode  <= 2'b10;
          end
        end
        WD_LO: if (press) begin
          wd[7:0] <= sw;
          state   <= WD_HI;
        end
        WD_HI: if (press) begin
          wd[15:8] <= sw;
          state    <= WRITE;
          we       <= 1'b1;
        end
        WRITE: state <= SHOW_W;
        SHOW_W: if (press) begin
          state <= CMD;
          mode  <= 2'b00;
        end
        RD_B: if (press) begin
          raB   <= sw[4:0];
          state <= SHOW_R;
          mode  <= 2'b11;
        end
        SHOW_R: if (press) begin
          state <= CMD;
          mode  <= 2'b00;
        end
        default: begin
          state <= CMD;
          mode  <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl with a short debounce window.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn;
  logic [7:0]  sw;
  logic [1:0]  mode;
  logic [4:0]  wa;
  logic [15:0] wd;
  logic        we;
  logic [4:0]  raA;
  logic [4:0]  raB;

  regfile_ctrl #(.DBNC(4)) dut (
    .clk(clk), .reset(reset), .btn(btn), .sw(sw), .mode(mode),
    .wa(wa), .wd(wd), .we(we), .raA(raA), .raB(raB)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [4:0]  raA;
    logic [4:0]  raB;
  } snap_t;

  typedef struct packed {
    logic [4:0]  wa;
    logic [15:0] wd;
  } wr_t;

  snap_t snap_q[$];
  wr_t   wr_q[$];

  int checks = 0;
  int errors = 0;
  int we_cycles = 0;
  logic we_prev = 1'b0;

  // Reference model
  int          ms;
  logic [4:0]  m_wa, m_raA, m_raB;
  logic [15:0] m_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_mode(input int s);
    case (s)
      1, 2, 3, 4: return 2'b01;
      5:          return 2'b10;
      6:          return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.mode = model_mode(ms);
    s.wa = m_wa; s.wd = m_wd; s.raA = m_raA; s.raB = m_raB;
    return s;
  endfunction

  task automatic model_reset();
    ms = 0; m_wa = '0; m_wd = '0; m_raA = '0; m_raB = '0;
  endtask

  task automatic model_press(input logic [7:0] v);
    wr_t w;
    case (ms)
      0: if (v[7]) begin m_wa = v[4:0]; ms = 1; end
         else begin m_raA = v[4:0]; ms = 5; end
      1: begin m_wd[7:0] = v; ms = 2; end
      2: begin
        m_wd[15:8] = v; ms = 4;
        w.wa = m_wa; w.wd = m_wd;
        wr_q.push_back(w);
      end
      5: begin m_raB = v[4:0]; ms = 6; end
      default: ms = 0;
    endcase
  endtask

  task automatic compare_snap(input string tag);
    snap_t e;
    if (snap_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    e = snap_q.pop_front();
    check({tag, "_mode"}, 32'(mode), 32'(e.mode));
    check({tag, "_wa"},   32'(wa),   32'(e.wa));
    check({tag, "_wd"},   32'(wd),   32'(e.wd));
    check({tag, "_raA"},  32'(raA),  32'(e.raA));
    check({tag, "_raB"},  32'(raB),  32'(e.raB));
  endtask

  task automatic press(input string tag, input logic [7:0] v, input int hold);
    sw = v;
    model_press(v);
    snap_q.push_back(model_snap());
    btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    compare_snap(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_we", 32'(we), 32'd0);
    snap_q.push_back(model_snap());
    compare_snap("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Write-port monitor: each pulse must be one cycle and match a queued write.
  always @(negedge clk) begin
    if (!reset && we) begin
      wr_t w;
      we_cycles++;
      check("we_width", 32'(we_prev), 32'd0);
      check("we_mode", 32'(mode), 32'd1);
      if (wr_q.size() == 0) begin
        check("we_spurious", 32'd1, 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("we_wa", 32'(wa), 32'(w.wa));
        check("we_wd", 32'(wd), 32'(w.wd));
      end
    end
    we_prev <= we;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    btn = 1'b0;
    sw = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // Write flow
    press("w_addr", 8'h83, 10);
    press("w_lo",   8'hCD, 10);
    press("w_hi",   8'hAB, 10);
    press("w_back", 8'h00, 10);
    check("we_count1", 32'(we_cycles), 32'd1);

    // Read flow
    press("r_a",    8'h05, 10);
    press("r_b",    8'h1F, 10);
    press("r_back", 8'h00, 10);
    check("we_count2", 32'(we_cycles), 32'd1);

    // Bounce: 3 high / 1 low never accumulates 4 samples
    sw = 8'h83;
    for (int i = 0; i < 12; i++) begin
      btn = 1'b1;
      repeat (3) @(negedge clk);
      btn = 1'b0;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    snap_q.push_back(model_snap());
    compare_snap("bounce");

    // Long hold gives exactly one press (CMD -> RD_B, not beyond)
    press("hold",   8'h02, 100);
    press("hold_b", 8'h00, 10);
    press("hold_x", 8'h00, 10);

    // Reset after partial data entry
    press("p_addr", 8'h8A, 10);
    press("p_lo",   8'h77, 10);
    do_reset();

    // Upper switch bits ignored
    press("u_addr", 8'hFF, 10);
    check("u_state", 32'(mode), 32'd1);
    press("u_lo",   8'h11, 10);
    press("u_hi",   8'h22, 10);
    press("u_back", 8'h00, 10);

    repeat (5) @(negedge clk);
    check("we_total", 32'(we_cycles), 32'd2);
    check("wr_pending", 32'(wr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
